// File: rtl/truth_table_scanner.sv
// Walks x/y/z through all eight combinations, samples F/Fn after a settle delay, and assembles the truth table.
// Optional golden-table comparator enabled by defining SCAN_EXPECT_CMP_EN.
module truth_table_scanner #(
    parameter int unsigned SETTLE   = 2,
    parameter logic [7:0]  EXPECTED = 8'h5C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       F_in,
    input  logic       Fn_in,
    output logic       x,
    output logic       y,
    output logic       z,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       err,
    output logic [2:0] fault_idx,
    output logic       match
);

    // state  | meaning
    // IDLE   | waiting for start, stimulus parked at 000
    // DRIVE  | holding {x,y,z} = idx while the settle counter runs
    // SAMPLE | capture F_in into table_out[idx], check Fn_in
    // DONE   | one-cycle completion pulse, match evaluated
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_e     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] xyz_q, xyz_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] table_q, table_d;
    logic       err_q, err_d;
    logic [2:0] fidx_q, fidx_d;
    logic       match_q, match_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        table_d = table_q;
        err_d   = err_q;
        fidx_d  = fidx_q;
        match_d = match_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    idx_d   = 3'd0;
                    cnt_d   = 4'd0;
                    table_d = 8'h00;
                    err_d   = 1'b0;
                    fidx_d  = 3'd0;
                    match_d = 1'b0;
                end
            end
            DRIVE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            SAMPLE: begin
                table_d[idx_q] = F_in;
                // only the first complement fault is recorded
                if ((F_in == Fn_in) && !err_q) begin
                    err_d  = 1'b1;
                    fidx_d = idx_q;
                end
                if (idx_q == 3'd7) begin
                    state_d = DONE;
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 3'd1;
                    cnt_d   = 4'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef SCAN_EXPECT_CMP_EN
                match_d = (table_q == EXPECTED) && !err_q;
`else
                match_d = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase

        // outputs registered from next state so they line up with the state register
        busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
        done_d = (state_d == DONE);
        xyz_d  = busy_d ? idx_d : 3'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            xyz_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            table_q <= 8'h00;
            err_q   <= 1'b0;
            fidx_q  <= 3'd0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            xyz_q   <= xyz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            table_q <= table_d;
            err_q   <= err_d;
            fidx_q  <= fidx_d;
            match_q <= match_d;
        end
    end

    assign x         = xyz_q[2];
    assign y         = xyz_q[1];
    assign z         = xyz_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign err       = err_q;
    assign fault_idx = fidx_q;
    assign match     = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: SETTLE=2 and SETTLE=1 instances driven by a behavioural function-block model.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst   = 1'b1;
    logic start = 1'b0;
    int   mode  = 0;   // 0: F = x'y + xz', 1: F stuck at 1, 2: Fn == F at indices 3 and 5

    int checks = 0;
    int errors = 0;

`ifdef SCAN_EXPECT_CMP_EN
    localparam logic EXP_MATCH = 1'b1;
`else
    localparam logic EXP_MATCH = 1'b0;
`endif

    logic       f2, fn2, x2, y2, z2, busy2, done2, err2, match2;
    logic [7:0] table2;
    logic [2:0] fidx2;
    logic       f1, fn1, x1, y1, z1, busy1, done1, err1, match1;
    logic [7:0] table1;
    logic [2:0] fidx1;

    truth_table_scanner #(.SETTLE(2), .EXPECTED(8'h5C)) dut2 (
        .clk(clk), .rst(rst), .start(start), .F_in(f2), .Fn_in(fn2),
        .x(x2), .y(y2), .z(z2), .busy(busy2), .done(done2),
        .table_out(table2), .err(err2), .fault_idx(fidx2), .match(match2)
    );

    truth_table_scanner #(.SETTLE(1), .EXPECTED(8'h5C)) dut1 (
        .clk(clk), .rst(rst), .start(start), .F_in(f1), .Fn_in(fn1),
        .x(x1), .y(y1), .z(z1), .busy(busy1), .done(done1),
        .table_out(table1), .err(err1), .fault_idx(fidx1), .match(match1)
    );

    always_comb begin
        f2  = (mode == 1) ? 1'b1 : ((~x2 & y2) | (x2 & ~z2));
        fn2 = ((mode == 2) && ({x2, y2, z2} == 3'd3 || {x2, y2, z2} == 3'd5)) ? f2 : ~f2;
        f1  = (mode == 1) ? 1'b1 : ((~x1 & y1) | (x1 & ~z1));
        fn1 = ((mode == 2) && ({x1, y1, z1} == 3'd3 || {x1, y1, z1} == 3'd5)) ? f1 : ~f1;
    end

    // Start a scan in cycle 0, observe dut2 for 40 cycles; extra starts may be pulsed in cycles ign_a/ign_b.
    task automatic run_scan2(input int ign_a, input int ign_b, output int done_first,
                             output int done_cnt, output int busy_bad, output int xyz_bad);
        done_first = -1;
        done_cnt   = 0;
        busy_bad   = 0;
        xyz_bad    = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done2) begin
                done_cnt++;
                if (done_first < 0) done_first = c;
            end
            if (busy2 !== (c <= 24)) busy_bad++;
            if ({x2, y2, z2} !== ((c <= 24) ? 3'((c - 1) / 3) : 3'd0)) xyz_bad++;
            if (c == ign_a || c == ign_b) start = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({x2, y2, z2, busy2, done2, table2, err2, fidx2, match2} !== 18'd0) begin
            errors++;
            $display("FAIL reset_dut2: got %b want all zero", {x2, y2, z2, busy2, done2, table2, err2, fidx2, match2});
        end
        checks++;
        if ({x1, y1, z1, busy1, done1, table1, err1, fidx1, match1} !== 18'd0) begin
            errors++;
            $display("FAIL reset_dut1: got %b want all zero", {x1, y1, z1, busy1, done1, table1, err1, fidx1, match1});
        end
        rst = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_correct_model();
        int df, dc, bb, xb;
        mode = 0;
        run_scan2(0, 0, df, dc, bb, xb);
        checks++; if (df !== 25) begin errors++; $display("FAIL correct_done_cycle: got %0d want 25", df); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL correct_done_count: got %0d want 1", dc); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL correct_busy_window: %0d bad cycles want 0", bb); end
        checks++; if (xb !== 0) begin errors++; $display("FAIL correct_xyz_sequence: %0d bad cycles want 0", xb); end
        checks++; if (table2 !== 8'h5C) begin errors++; $display("FAIL correct_table: got %h want 5c", table2); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL correct_err: got %b want 0", err2); end
        checks++; if (fidx2 !== 3'd0) begin errors++; $display("FAIL correct_fault_idx: got %0d want 0", fidx2); end
        checks++; if (match2 !== EXP_MATCH) begin errors++; $display("FAIL correct_match: got %b want %b", match2, EXP_MATCH); end
    endtask

    task automatic test_stuck_at();
        int df, dc, bb, xb;
        mode = 1;
        run_scan2(0, 0, df, dc, bb, xb);
        checks++; if (df !== 25) begin errors++; $display("FAIL stuck_done_cycle: got %0d want 25", df); end
        checks++; if (table2 !== 8'hFF) begin errors++; $display("FAIL stuck_table: got %h want ff", table2); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL stuck_err: got %b want 0", err2); end
        checks++; if (match2 !== 1'b0) begin errors++; $display("FAIL stuck_match: got %b want 0", match2); end
    endtask

    task automatic test_complement_fault();
        int df, dc, bb, xb;
        mode = 2;
        run_scan2(0, 0, df, dc, bb, xb);
        checks++; if (err2 !== 1'b1) begin errors++; $display("FAIL cfault_err: got %b want 1", err2); end
        checks++; if (fidx2 !== 3'd3) begin errors++; $display("FAIL cfault_fault_idx: got %0d want 3", fidx2); end
        checks++; if (table2 !== 8'h5C) begin errors++; $display("FAIL cfault_table: got %h want 5c", table2); end
        checks++; if (match2 !== 1'b0) begin errors++; $display("FAIL cfault_match: got %b want 0", match2); end
    endtask

    task automatic test_reset_mid_scan();
        int df, dc, bb, xb;
        mode = 0;
        @(posedge clk); #1;
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            rst = 1'b0;
            if (c == 10) begin
                checks++;
                if (table2 !== 8'h04) begin errors++; $display("FAIL midrst_partial_table: got %h want 04", table2); end
                rst = 1'b1;
            end
            if (c == 11) begin
                checks++;
                if ({x2, y2, z2, busy2, done2, table2, err2, fidx2, match2} !== 18'd0) begin
                    errors++;
                    $display("FAIL midrst_outputs: got %b want all zero", {x2, y2, z2, busy2, done2, table2, err2, fidx2, match2});
                end
            end
            if (c == 12) begin
                checks++;
                if (busy2 !== 1'b0) begin errors++; $display("FAIL midrst_stays_idle: busy %b want 0", busy2); end
            end
        end
        // starts during busy (cycle 5) and in DONE (cycle 25) must be ignored
        run_scan2(5, 25, df, dc, bb, xb);
        checks++; if (df !== 25) begin errors++; $display("FAIL ignored_start_done_cycle: got %0d want 25", df); end
        checks++; if (dc !== 1) begin errors++; $display("FAIL ignored_start_done_count: got %0d want 1", dc); end
        checks++; if (bb !== 0) begin errors++; $display("FAIL ignored_start_busy: %0d bad cycles want 0", bb); end
        checks++; if (table2 !== 8'h5C) begin errors++; $display("FAIL ignored_start_table: got %h want 5c", table2); end
    endtask

    task automatic test_back_to_back();
        int d_first, d_second, d_cnt, xb;
        logic [2:0] exp_xyz;
        d_first = -1; d_second = -1; d_cnt = 0; xb = 0;
        mode = 2;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done1) begin
                d_cnt++;
                if (d_first < 0) d_first = c; else if (d_second < 0) d_second = c;
            end
            if (c <= 16) exp_xyz = 3'((c - 1) / 2);
            else if (c >= 19 && c <= 34) exp_xyz = 3'((c - 19) / 2);
            else exp_xyz = 3'd0;
            if ({x1, y1, z1} !== exp_xyz) xb++;
            if (c == 18) begin
                checks++;
                if ({table1, err1, fidx1} !== {8'h5C, 1'b1, 3'd3}) begin
                    errors++;
                    $display("FAIL b2b_first_results: got %h/%b/%0d want 5c/1/3", table1, err1, fidx1);
                end
                start = 1'b1;
            end
            if (c == 19) begin
                checks++;
                if ({table1, err1, fidx1, match1, busy1} !== {8'h00, 1'b0, 3'd0, 1'b0, 1'b1}) begin
                    errors++;
                    $display("FAIL b2b_results_clear: got %h/%b/%0d/%b busy %b want 00/0/0/0 busy 1",
                             table1, err1, fidx1, match1, busy1);
                end
            end
        end
        checks++; if (d_first !== 17) begin errors++; $display("FAIL b2b_first_done: got %0d want 17", d_first); end
        checks++; if (d_second !== 35) begin errors++; $display("FAIL b2b_second_done: got %0d want 35", d_second); end
        checks++; if (d_cnt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", d_cnt); end
        checks++; if (xb !== 0) begin errors++; $display("FAIL b2b_xyz_sequence: %0d bad cycles want 0", xb); end
    endtask

    initial begin
        test_reset();
        test_correct_model();
        test_stuck_at();
        test_complement_fault();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
